// File: rtl/map_arbiter.sv
// Two-requester arbiter for the shared map ROM.
// Tracer has priority; a starvation counter force-grants the overlay.
module map_arbiter #(
  parameter int COLBITS      = 4,
  parameter int ROWBITS      = 4,
  parameter int BITS         = 2,
  parameter int STARVE_LIMIT = 15,
  parameter int CNTBITS      = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               halt,
  input  logic               t_valid,
  output logic               t_ready,
  input  logic [COLBITS-1:0] t_col,
  input  logic [ROWBITS-1:0] t_row,
  output logic               t_rvalid,
  output logic [BITS-1:0]    t_rdata,
  input  logic               o_valid,
  output logic               o_ready,
  input  logic [COLBITS-1:0] o_col,
  input  logic [ROWBITS-1:0] o_row,
  output logic               o_rvalid,
  output logic [BITS-1:0]    o_rdata,
  output logic [COLBITS-1:0] map_col,
  output logic [ROWBITS-1:0] map_row,
  input  logic [BITS-1:0]    map_val,
  output logic               starved
);

  localparam logic [CNTBITS-1:0] LIMIT =
    CNTBITS'(STARVE_LIMIT);
  localparam logic HAS_LIMIT =
    1'(STARVE_LIMIT != 0);

  logic [CNTBITS-1:0] cnt;
  logic               s1_valid;
  logic               owner;
  logic               force_o;
  logic               gnt_t;
  logic               gnt_o;

  assign starved = HAS_LIMIT & (cnt == LIMIT);
  assign force_o = starved & o_valid;

  // No handshakes while held in reset.
  assign t_ready = reset_n & ~halt & ~force_o;
  assign o_ready = reset_n & ~halt
                 & (~t_valid | force_o);

  assign gnt_t = t_valid & t_ready;
  assign gnt_o = o_valid & o_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      map_col  <= '0;
      map_row  <= '0;
      owner    <= 1'b0;
      s1_valid <= 1'b0;
    end else if (gnt_o) begin
      map_col  <= o_col;
      map_row  <= o_row;
      owner    <= 1'b1;
      s1_valid <= 1'b1;
    end else if (gnt_t) begin
      map_col  <= t_col;
      map_row  <= t_row;
      owner    <= 1'b0;
      s1_valid <= 1'b1;
    end else begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_rvalid <= 1'b0;
      o_rvalid <= 1'b0;
      t_rdata  <= '0;
      o_rdata  <= '0;
    end else begin
      t_rvalid <= s1_valid & ~owner;
      o_rvalid <= s1_valid & owner;
      if (s1_valid & ~owner)
        t_rdata <= map_val;
      if (s1_valid & owner)
        o_rdata <= map_val;
    end
  end

  // Saturates at LIMIT; stays 0 when LIMIT is 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!halt) begin
      if (gnt_o || !o_valid)
        cnt <= '0;
      else if (cnt != LIMIT)
        cnt <= cnt + CNTBITS'(1);
    end
  end

endmodule

// File: tb/tb_map_arbiter.sv
// Bench for map_arbiter: two instances (limit 15 and
// strict priority) against a queue-based reference model.
module tb_map_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, halt, t_valid, o_valid;
  logic [3:0] t_col, t_row, o_col, o_row;
  logic [1:0] t_ready, o_ready;
  logic [1:0] t_rvalid, o_rvalid, starved;
  logic [1:0] t_rdata [2];
  logic [1:0] o_rdata [2];
  logic [1:0] map_val [2];
  logic [3:0] map_col [2];
  logic [3:0] map_row [2];
  logic [1:0] rom [16][16];

  assign map_val[0] = rom[map_col[0]][map_row[0]];
  assign map_val[1] = rom[map_col[1]][map_row[1]];

  map_arbiter #(.STARVE_LIMIT(15)) u_a (
    .clk(clk), .reset_n(reset_n), .halt(halt),
    .t_valid(t_valid), .t_ready(t_ready[0]),
    .t_col(t_col), .t_row(t_row),
    .t_rvalid(t_rvalid[0]), .t_rdata(t_rdata[0]),
    .o_valid(o_valid), .o_ready(o_ready[0]),
    .o_col(o_col), .o_row(o_row),
    .o_rvalid(o_rvalid[0]), .o_rdata(o_rdata[0]),
    .map_col(map_col[0]), .map_row(map_row[0]),
    .map_val(map_val[0]), .starved(starved[0])
  );

  map_arbiter #(.STARVE_LIMIT(0)) u_b (
    .clk(clk), .reset_n(reset_n), .halt(halt),
    .t_valid(t_valid), .t_ready(t_ready[1]),
    .t_col(t_col), .t_row(t_row),
    .t_rvalid(t_rvalid[1]), .t_rdata(t_rdata[1]),
    .o_valid(o_valid), .o_ready(o_ready[1]),
    .o_col(o_col), .o_row(o_row),
    .o_rvalid(o_rvalid[1]), .o_rdata(o_rdata[1]),
    .map_col(map_col[1]), .map_row(map_row[1]),
    .map_val(map_val[1]), .starved(starved[1])
  );

  typedef struct {
    int         inst;
    bit         own;
    logic [1:0] d;
    int         due;
  } resp_t;

  resp_t      rq[$];
  int         lim [2] = '{15, 0};
  int         den [2];
  logic [3:0] m_col [2];
  logic [3:0] m_row [2];
  logic [1:0] m_td [2];
  logic [1:0] m_od [2];
  bit         m_tr [2];
  bit         m_or [2];
  int         tv_seen [2];
  int         ov_seen [2];
  int         t_hs [2];
  int         o_hs [2];
  int         checks = 0;
  int         errors = 0;
  int         edge_no = 0;

  task automatic chk(string tag, int i,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h",
             tag, i, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      den[i]   = 0;
      m_col[i] = '0;
      m_row[i] = '0;
      m_td[i]  = '0;
      m_od[i]  = '0;
    end
    rq.delete();
  endtask

  task automatic check_outs();
    bit    ost, etv, eov;
    resp_t keep[$];
    for (int i = 0; i < 2; i++) begin
      ost = (lim[i] != 0) && (den[i] == lim[i]);
      m_tr[i] = reset_n && !halt && !(ost && o_valid);
      m_or[i] = reset_n && !halt &&
                (!t_valid || (ost && o_valid));
      etv = 0;
      eov = 0;
      foreach (rq[k]) begin
        if (rq[k].inst == i && rq[k].due == edge_no) begin
          if (rq[k].own) begin
            eov = 1;
            m_od[i] = rq[k].d;
          end else begin
            etv = 1;
            m_td[i] = rq[k].d;
          end
        end
      end
      chk("t_ready", i, 32'(t_ready[i]), 32'(m_tr[i]));
      chk("o_ready", i, 32'(o_ready[i]), 32'(m_or[i]));
      chk("starved", i, 32'(starved[i]), 32'(ost));
      chk("map_col", i, 32'(map_col[i]), 32'(m_col[i]));
      chk("map_row", i, 32'(map_row[i]), 32'(m_row[i]));
      chk("t_rvalid", i, 32'(t_rvalid[i]), 32'(etv));
      chk("o_rvalid", i, 32'(o_rvalid[i]), 32'(eov));
      chk("t_rdata", i, 32'(t_rdata[i]), 32'(m_td[i]));
      chk("o_rdata", i, 32'(o_rdata[i]), 32'(m_od[i]));
      tv_seen[i] += 32'(t_rvalid[i]);
      ov_seen[i] += 32'(o_rvalid[i]);
      t_hs[i] += 32'(t_valid & t_ready[i]);
      o_hs[i] += 32'(o_valid & o_ready[i]);
    end
    foreach (rq[k])
      if (rq[k].due > edge_no) keep.push_back(rq[k]);
    rq = keep;
  endtask

  task automatic model_edge();
    edge_no++;
    if (reset_n) begin
      for (int i = 0; i < 2; i++) begin
        if (t_valid && m_tr[i]) begin
          rq.push_back('{i, 1'b0, rom[t_col][t_row],
                         edge_no + 1});
          m_col[i] = t_col;
          m_row[i] = t_row;
        end else if (o_valid && m_or[i]) begin
          rq.push_back('{i, 1'b1, rom[o_col][o_row],
                         edge_no + 1});
          m_col[i] = o_col;
          m_row[i] = o_row;
        end
        if (!halt) begin
          if ((o_valid && m_or[i]) || !o_valid)
            den[i] = 0;
          else if (den[i] < lim[i])
            den[i]++;
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_outs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rst_pulse();
    reset_n = 1'b0;
    model_clear();
    #1;
    check_outs();
    reset_n = 1'b1;
  endtask

  int b_tv, b_ov0, b_ov1, b_oh0, b_oh1, b_th0;

  initial begin
    for (int c = 0; c < 16; c++)
      for (int r = 0; r < 16; r++)
        rom[c][r] = 2'($urandom_range(0, 3));
    reset_n = 1'b1;
    halt    = 1'b0;
    t_valid = 1'b1;
    o_valid = 1'b1;
    t_col = 4'd9; t_row = 4'd2;
    o_col = 4'd4; o_row = 4'd11;
    #1;
    reset_n = 1'b0;
    model_clear();
    repeat (3) cyc();

    // first tracer read after reset release
    o_valid = 1'b0;
    t_col = 4'd3; t_row = 4'd5;
    reset_n = 1'b1;
    cyc();
    t_valid = 1'b0;
    chk("first_col", 0, 32'(map_col[0]), 32'd3);
    chk("first_row", 0, 32'(map_row[0]), 32'd5);
    cyc();
    chk("first_rv", 0, 32'(t_rvalid[0]), 32'd1);
    chk("first_rd", 0, 32'(t_rdata[0]),
        32'(rom[3][5]));
    cyc();

    // back-to-back tracer stream
    b_tv = tv_seen[0];
    b_ov0 = ov_seen[0];
    t_valid = 1'b1;
    t_row = 4'd7;
    for (int k = 0; k < 16; k++) begin
      t_col = 4'(k);
      cyc();
    end
    t_valid = 1'b0;
    repeat (2) cyc();
    chk("b2b_tv", 0, 32'(tv_seen[0] - b_tv), 32'd16);
    chk("b2b_ov", 0, 32'(ov_seen[0] - b_ov0), 32'd0);

    // contention: limit 15 vs strict priority
    cyc();
    b_oh0 = o_hs[0];
    b_oh1 = o_hs[1];
    b_th0 = t_hs[0];
    t_valid = 1'b1;
    o_valid = 1'b1;
    for (int k = 0; k < 96; k++) begin
      t_col = 4'($urandom); t_row = 4'($urandom);
      o_col = 4'($urandom); o_row = 4'($urandom);
      cyc();
    end
    chk("cont_o", 0, 32'(o_hs[0] - b_oh0), 32'd6);
    chk("cont_t", 0, 32'(t_hs[0] - b_th0), 32'd90);
    chk("strict_o", 1, 32'(o_hs[1] - b_oh1), 32'd0);
    t_valid = 1'b0;
    b_oh1 = o_hs[1];
    cyc();
    chk("drop_t_o", 1, 32'(o_hs[1] - b_oh1), 32'd1);

    // halt with two reads in flight
    t_valid = 1'b1;
    repeat (5) cyc();
    b_tv = tv_seen[0];
    b_th0 = t_hs[0];
    halt = 1'b1;
    repeat (5) cyc();
    chk("halt_tv", 0, 32'(tv_seen[0] - b_tv), 32'd2);
    chk("halt_hs", 0, 32'(t_hs[0] - b_th0), 32'd0);
    halt = 1'b0;
    repeat (15) cyc();

    // reset between E0 and E1 of an overlay read
    t_valid = 1'b0;
    o_valid = 1'b1;
    o_col = 4'd13; o_row = 4'd6;
    cyc();
    o_valid = 1'b0;
    b_ov0 = ov_seen[0];
    b_ov1 = ov_seen[1];
    rst_pulse();
    repeat (3) cyc();
    chk("mrst_ov", 0, 32'(ov_seen[0] - b_ov0), 32'd0);
    chk("mrst_ov", 1, 32'(ov_seen[1] - b_ov1), 32'd0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      t_valid = ($urandom_range(0, 3) != 0);
      o_valid = ($urandom_range(0, 1) != 0);
      halt    = ($urandom_range(0, 9) == 0);
      t_col = 4'($urandom); t_row = 4'($urandom);
      o_col = 4'($urandom); o_row = 4'($urandom);
      if ($urandom_range(0, 299) == 0)
        rst_pulse();
      cyc();
    end
    halt = 1'b0;
    t_valid = 1'b0;
    o_valid = 1'b0;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/map_arbiter.md
Name: map_arbiter

Overview:
- Shares the single combinational map ROM between two requesters.
- Requester T is the ray tracer DDA stepper and has high priority; requester O is the map overlay / debug readout and has low priority.
- Registers the granted cell address and drives it onto the map ROM row/col inputs, then registers the returned cell value, tagged by owner.
- Includes an anti-starvation counter so the overlay still makes progress during long trace bursts.

Parameters:
COLBITS, 4, map column address width
ROWBITS, 4, map row address width
BITS, 2, map cell value width
STARVE_LIMIT, 15, number of consecutive denied overlay cycles before the overlay is force-granted; 0 means strict priority
CNTBITS, 4, width of the starvation counter; must hold STARVE_LIMIT

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
halt  in  1  when high, no new grants are made; in-flight reads still complete
t_valid  in  1  tracer request valid
t_ready  out  1  tracer request accepted this cycle
t_col  in  COLBITS  tracer cell column
t_row  in  ROWBITS  tracer cell row
t_rvalid  out  1  tracer response strobe
t_rdata  out  BITS  tracer cell value
o_valid  in  1  overlay request valid
o_ready  out  1  overlay request accepted this cycle
o_col  in  COLBITS  overlay cell column
o_row  in  ROWBITS  overlay cell row
o_rvalid  out  1  overlay response strobe
o_rdata  out  BITS  overlay cell value
map_col  out  COLBITS  to map ROM col input
map_row  out  ROWBITS  to map ROM row input
map_val  in  BITS  from map ROM, combinational in map_col/map_row
starved  out  1  high while the force-grant to the overlay is pending

Behaviour:
- Clocking and reset:
  - reset_n is asynchronous and active-low; one clock.
  - Reset forces: map_col=0, map_row=0, stage-1 valid=0, owner=0, t_rvalid=0, o_rvalid=0, t_rdata=0, o_rdata=0, starve counter=0, starved=0.
- Grant logic (combinational, each cycle):
  - force = starved & o_valid.
  - gnt_t = ~halt & t_valid & ~force.
  - gnt_o = ~halt & o_valid & (~t_valid | force).
  - t_ready = ~halt & ~force.
  - o_ready = ~halt & (~t_valid | force).
  - ready may depend on the other requester's valid. A request is accepted on a rising edge where valid & ready.
  - At most one grant per cycle.
- Stage 1 (rising edge E0, when a grant is made):
  - map_col/map_row are loaded from the winner's col/row.
  - owner is loaded (0=T, 1=O) and s1_valid=1.
  - With no grant, s1_valid=0 and map_col/map_row hold their value.
- Stage 2 (edge E1):
  - If s1_valid, map_val is captured into the owner's rdata, and that owner's rvalid is high for exactly the cycle after E1.
  - The other rvalid is 0. When s1_valid=0, both rvalids are 0.
  - rdata holds its last value when not strobed.
- Latency and throughput:
  - Latency is 2 edges from acceptance to response data.
  - Full throughput: 1 accept per cycle, back-to-back, with no bubbles.
  - Responses have no backpressure; requesters must sink them.
  - Responses return in acceptance order.
- Starvation counter:
  - Counter increments (saturating at STARVE_LIMIT) on each edge where o_valid & ~o_ready & ~halt.
  - Counter clears on an overlay grant or when o_valid=0.
  - starved = (STARVE_LIMIT!=0) & (cnt==STARVE_LIMIT).
  - Force grants one overlay request, then the counter clears and tracer priority resumes.
- halt:
  - Both readies are 0 and the counter freezes.
  - Stage 1/2 contents already accepted still drain normally.
- Boundary cases:
  - Simultaneous valid with starved=0: tracer wins, and o_ready=0.
  - Address arithmetic: none; coordinates pass through unmodified, with full COLBITS/ROWBITS wrap.
  - Reset asserted mid-read: the in-flight response is discarded; no rvalid follows reset release.
  - Requester valid dropped without a handshake: no effect on any state.

Test Plan:
- Reset behaviour: hold reset_n=0 with requests active -> all outputs 0. Release -> the first T request (col=3,row=5) gives map_col=3, map_row=5 after E0, and t_rvalid=1 with t_rdata equal to the model ROM[3][5] in the cycle after E1.
- Back-to-back tracer reads: T streams 16 cells (col 0..15, row 7) -> t_ready continuously 1, 16 consecutive t_rvalid pulses, values in order, o_rvalid stays 0.
- Contention: T and O both valid continuously with STARVE_LIMIT=15 -> O denied 15 cycles, starved=1, one O grant on the 16th cycle (t_ready=0 that cycle), then T resumes. The pattern repeats every 16 accepts.
- Strict priority: STARVE_LIMIT=0, both valid for 100 cycles -> zero O grants and starved never 1. Dropping t_valid -> O granted the same cycle.
- halt: assert halt for 5 cycles mid-stream with 2 reads in flight -> those 2 responses still arrive, no new accepts, starve counter value unchanged after halt releases.
- Mid-read reset: pulse reset_n low between E0 and E1 of an O read -> o_rvalid never asserts, and all outputs are 0 during reset.
